// File: rtl/pwm_peripheral.sv
// ---------------------------------------------------------------------------
// pwm_peripheral
//
// Drives 16 user outputs as either static-high or PWM. A prescaler and an
// 8-bit period counter produce one duty cycle shared by all channels. The
// requested duty goes through a shadow register that is only reloaded at the
// period wrap, so a duty change never truncates or stretches a pulse.
//
// Parameters:
//   PRESCALE         clk cycles per PWM step (>= 1); period = 256*PRESCALE
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   en_reg_out_7_0   output enable, channels 7..0
//   en_reg_out_15_8  output enable, channels 15..8
//   en_reg_pwm_7_0   mode select, channels 7..0 (1 = PWM, 0 = static high)
//   en_reg_pwm_15_8  mode select, channels 15..8
//   pwm_duty_cycle   requested duty (0x00 = always low, 0xFF = always high)
//   uo_out           registered outputs, channels 7..0
//   uio_out          registered outputs, channels 15..8
//   period_start     one-cycle pulse in the first cycle of every period
// ---------------------------------------------------------------------------
module pwm_peripheral #(
    parameter int PRESCALE = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] en_reg_out_7_0,
    input  logic [7:0] en_reg_out_15_8,
    input  logic [7:0] en_reg_pwm_7_0,
    input  logic [7:0] en_reg_pwm_15_8,
    input  logic [7:0] pwm_duty_cycle,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic       period_start
);

    localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_cnt_q, presc_cnt_d;
    logic [7:0]    pwm_cnt_q,   pwm_cnt_d;
    logic [7:0]    duty_sh_q,   duty_sh_d;
    logic [15:0]   out_q,       out_d;
    logic          period_start_q;

    logic          tick;
    logic          wrap;
    logic          pwm_high;
    logic [15:0]   en_out;
    logic [15:0]   en_pwm;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    always_comb begin
        // NOTE: every signal gets a value on every path through this block,
        // otherwise synthesis infers a latch to hold the old value.
        tick        = (presc_cnt_q == PRESC_MAX);
        wrap        = tick && (pwm_cnt_q == 8'hFF);
        presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
        // 8-bit add wraps 255 -> 0 on its own; no saturation wanted.
        pwm_cnt_d   = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        duty_sh_d   = wrap ? pwm_duty_cycle : duty_sh_q;
        // Compare against next-state counter and shadow so the registered
        // output rises in the same cycle as the registered period_start.
        // 0xFF is forced to 100% high; 255/256 is deliberately unreachable.
        pwm_high    = (duty_sh_d == 8'hFF) || (pwm_cnt_d < duty_sh_d);
        // Disable wins over mode; non-PWM enabled channels are static high.
        out_d       = en_out & (~en_pwm | {16{pwm_high}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_q    <= '0;
            pwm_cnt_q      <= '0;
            duty_sh_q      <= '0;
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            presc_cnt_q    <= presc_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            duty_sh_q      <= duty_sh_d;
            out_q          <= out_d;
            period_start_q <= wrap;
        end
    end

    assign uo_out       = out_q[7:0];
    assign uio_out      = out_q[15:8];
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// ---------------------------------------------------------------------------
// tb_pwm_peripheral
//
// Directed bench for pwm_peripheral with PRESCALE = 13 (period 3328 cycles).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_pwm_peripheral;

    localparam int PRESCALE = 13;
    localparam int PERIOD   = 256 * PRESCALE;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic       period_start;

    int n_cmp = 0;
    int n_err = 0;

    int mism [16];
    bit spacing_ok;

    pwm_peripheral #(.PRESCALE(PRESCALE)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .uo_out          (uo_out),
        .uio_out         (uio_out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    task automatic set_en(input logic [15:0] en_out, input logic [15:0] en_pwm);
        en_reg_out_7_0  = en_out[7:0];
        en_reg_out_15_8 = en_out[15:8];
        en_reg_pwm_7_0  = en_pwm[7:0];
        en_reg_pwm_15_8 = en_pwm[15:8];
    endtask

    // Advance falling edges until period_start is seen or the budget runs out.
    task automatic wait_ps(input int budget, output int cycles, output bit found,
                           output bit saw_out);
        found   = 1'b0;
        saw_out = 1'b0;
        cycles  = 0;
        while (!found && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (period_start) found = 1'b1;
            else if (uo_out != 8'h00 || uio_out != 8'h00) saw_out = 1'b1;
        end
    endtask

    // Called on the falling edge where period_start is high. Walks one full
    // period, recording per channel how many cycles differ from "high for the
    // first n_high cycles, low after". Optionally changes the duty input at
    // index chg_at. Ends on the falling edge of the next period's first cycle.
    task automatic measure(input int n_high, input int chg_at, input logic [7:0] chg_duty);
        bit v;
        int extra = 0;
        for (int ch = 0; ch < 16; ch++) mism[ch] = 0;
        for (int i = 0; i < PERIOD; i++) begin
            for (int ch = 0; ch < 16; ch++) begin
                v = (ch < 8) ? uo_out[ch] : uio_out[ch-8];
                if (v != (i < n_high)) mism[ch]++;
            end
            if (i > 0 && period_start) extra++;
            if (i == chg_at) pwm_duty_cycle = chg_duty;
            @(negedge clk);
        end
        spacing_ok = period_start && (extra == 0);
    endtask

    task automatic check_period(input string name);
        for (int ch = 0; ch < 16; ch++) begin
            n_cmp++;
            if (mism[ch] !== 0) begin
                n_err++;
                $display("FAIL %s ch%0d: %0d cycles off expected waveform, required 0",
                         name, ch, mism[ch]);
            end
        end
        n_cmp++;
        if (spacing_ok !== 1'b1) begin
            n_err++;
            $display("FAIL %s spacing: period_start not exactly %0d apart", name, PERIOD);
        end
    endtask

    task automatic test_reset();
        int  cyc;
        bit  found, saw;
        rst_n = 1'b0;
        set_en(16'h0000, 16'h0000);
        pwm_duty_cycle = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({uo_out, uio_out, period_start} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got uo=%h uio=%h ps=%b, required all 0",
                     uo_out, uio_out, period_start);
        end
        rst_n = 1'b1;
        wait_ps(PERIOD + 16, cyc, found, saw);
        n_cmp++;
        if (!found || cyc != PERIOD) begin
            n_err++;
            $display("FAIL reset_first_ps: got %0d cycles (found=%0b), required %0d",
                     cyc, found, PERIOD);
        end
    endtask

    task automatic test_static();
        n_cmp++;
        if (uo_out !== 8'h00) begin
            n_err++;
            $display("FAIL static_before: uo=%h, required 00", uo_out);
        end
        set_en(16'h0001, 16'h0000);
        pwm_duty_cycle = 8'h80;
        @(negedge clk);
        n_cmp++;
        if (uo_out !== 8'h01 || uio_out !== 8'h00) begin
            n_err++;
            $display("FAIL static_enable: uo=%h uio=%h, required 01 00", uo_out, uio_out);
        end
        repeat (400) @(negedge clk);
        n_cmp++;
        if (uo_out !== 8'h01 || uio_out !== 8'h00) begin
            n_err++;
            $display("FAIL static_hold: uo=%h uio=%h, required 01 00", uo_out, uio_out);
        end
    endtask

    task automatic test_duty40();
        int cyc;
        bit found, saw;
        set_en(16'hFFFF, 16'hFFFF);
        pwm_duty_cycle = 8'h40;
        for (int k = 0; k < 2; k++) begin
            wait_ps(PERIOD + 16, cyc, found, saw);
            n_cmp++;
            if (!found) begin
                n_err++;
                $display("FAIL duty40_wait%0d: period_start not seen in %0d cycles", k, cyc);
            end
        end
        measure(832, -1, 8'h00);
        check_period("duty40");
    endtask

    task automatic test_extremes();
        // Write one cycle after the wrap edge: current period keeps 0x40.
        pwm_duty_cycle = 8'h00;
        measure(832, -1, 8'h00);
        check_period("duty00_pending");
        measure(0, -1, 8'h00);
        check_period("duty00");
        pwm_duty_cycle = 8'hFF;
        measure(0, -1, 8'h00);
        check_period("dutyFF_pending");
        for (int k = 0; k < 3; k++) begin
            measure(PERIOD, -1, 8'h00);
            check_period($sformatf("dutyFF_p%0d", k));
        end
    endtask

    task automatic test_duty_change();
        pwm_duty_cycle = 8'h40;
        measure(PERIOD, -1, 8'h00);
        check_period("chg_restore");
        // 0x40 -> 0xC0 in the middle of a period.
        measure(832, 1000, 8'hC0);
        check_period("chg_mid_current");
        // Change applied in the last cycle before the wrap edge is captured.
        measure(2496, PERIOD - 1, 8'h10);
        check_period("chg_mid_next");
        measure(208, -1, 8'h00);
        check_period("chg_at_wrap");
    endtask

    task automatic test_en_clear();
        // Positioned at a period start with duty 0x10 (208 high cycles).
        repeat (50) @(negedge clk);
        n_cmp++;
        if (uo_out !== 8'hFF) begin
            n_err++;
            $display("FAIL en_clear_before: uo=%h, required FF", uo_out);
        end
        set_en(16'hFFDF, 16'hFFFF);
        @(negedge clk);
        n_cmp++;
        if (uo_out !== 8'hDF || uio_out !== 8'hFF) begin
            n_err++;
            $display("FAIL en_clear_next: uo=%h uio=%h, required DF FF", uo_out, uio_out);
        end
        repeat (100) @(negedge clk);
        n_cmp++;
        if (uo_out !== 8'hDF) begin
            n_err++;
            $display("FAIL en_clear_hold: uo=%h, required DF", uo_out);
        end
        set_en(16'hFFFF, 16'hFFFF);
        @(negedge clk);
        n_cmp++;
        if (uo_out !== 8'hFF) begin
            n_err++;
            $display("FAIL en_restore: uo=%h, required FF", uo_out);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit found, saw;
        wait_ps(PERIOD + 16, cyc, found, saw);
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL rst_mid_wait: period_start not seen in %0d cycles", cyc);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (uo_out !== 8'hFF || uio_out !== 8'hFF) begin
            n_err++;
            $display("FAIL rst_mid_before: uo=%h uio=%h, required FF FF", uo_out, uio_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({uo_out, uio_out, period_start} !== 17'h0) begin
            n_err++;
            $display("FAIL rst_mid_async: uo=%h uio=%h ps=%b, required all 0",
                     uo_out, uio_out, period_start);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ps(PERIOD + 16, cyc, found, saw);
        n_cmp++;
        if (!found || cyc != PERIOD) begin
            n_err++;
            $display("FAIL rst_mid_first_ps: got %0d cycles (found=%0b), required %0d",
                     cyc, found, PERIOD);
        end
        // Shadow restarts at 0, so PWM channels stay low for the first period.
        n_cmp++;
        if (saw !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_shadow: outputs went high before first wrap, required low");
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_duty40();
        test_extremes();
        test_duty_change();
        test_en_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
